// File: rtl/fresh_sched_pkg.sv
// fresh_sched_pkg: shared FSM encoding and ID sizing helper for the fresh-bit poll scheduler
package fresh_sched_pkg;
  typedef enum logic [1:0] {IDLE, PRESENT, ACK} state_t;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fresh_poll_sched_rr_pick.sv
// rr_pick: combinational round-robin finder, first set bit of req at or after last_id+1 (wrapping)
// Ports: req (request vector), last_id (previous winner), sel (chosen index), any (req nonzero)
module rr_pick import fresh_sched_pkg::*; #(
  parameter int N = 8,
  localparam int W = id_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_id,
  output logic [W-1:0] sel,
  output logic         any
);
  // Scanning from the farthest offset down lets the nearest hit win.
  always_comb begin
    sel = '0;
    for (int k = N; k >= 1; k--)
      if (req[W'((int'(last_id) + k) % N)]) sel = W'((int'(last_id) + k) % N);
  end
  assign any = |req;
endmodule

// File: rtl/fresh_poll_sched.sv
// fresh_poll_sched: round-robin scheduler turning axi_slave fresh bits into one valid/ready stream
// Ports: clk, rst (sync active-high); fresh_bits/rtl_rd_out/poll_mask from the slave side;
//   rtl_rdy per-ID acknowledge back to the slave; out_valid/out_ready/out_id/out_data stream;
//   ack_err sticky ACK-timeout flag. Optional FRESH_POLL_STATS_EN adds served_cnt (handshake count).
`ifndef MEM_SIZE
`define MEM_SIZE 8
`endif
`ifndef WD_DATA_WIDTH
`define WD_DATA_WIDTH 32
`endif
module fresh_poll_sched import fresh_sched_pkg::*; #(
  parameter int MEM_SIZE    = `MEM_SIZE,
  parameter int DATA_WIDTH  = `WD_DATA_WIDTH,
  parameter int ACK_TIMEOUT = 8,
  localparam int IW = id_width(MEM_SIZE)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [MEM_SIZE-1:0]                  fresh_bits,
  input  logic [MEM_SIZE-1:0][DATA_WIDTH-1:0]  rtl_rd_out,
  input  logic [MEM_SIZE-1:0]                  poll_mask,
  output logic [MEM_SIZE-1:0]                  rtl_rdy,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [IW-1:0]                        out_id,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 ack_err
`ifdef FRESH_POLL_STATS_EN
  ,
  output logic [31:0]                          served_cnt
`endif
);
  localparam int TW = id_width(ACK_TIMEOUT) + 1;
  state_t                state;
  logic [IW-1:0]         cur_id, last_id, sel;
  logic [TW-1:0]         timer;
  logic                  any;
  logic [MEM_SIZE-1:0]   cur_hot;
  rr_pick #(.N(MEM_SIZE)) u_pick (
    .req     (fresh_bits & poll_mask),
    .last_id (last_id),
    .sel     (sel),
    .any     (any)
  );
  assign cur_hot = MEM_SIZE'(1) << cur_id;
  // The owned ID's rtl_rdy is FSM-driven while in PRESENT/ACK; every other bit follows ~poll_mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
      rtl_rdy   <= '0;
      ack_err   <= 1'b0;
      cur_id    <= '0;
      last_id   <= IW'(MEM_SIZE - 1);
      timer     <= '0;
    end else begin
      case (state)
        IDLE: begin
          rtl_rdy <= ~poll_mask;
          if (any) begin
            cur_id    <= sel;
            out_id    <= sel;
            out_data  <= rtl_rd_out[sel];
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          rtl_rdy <= out_ready ? (~poll_mask | cur_hot) : (~poll_mask & ~cur_hot);
          if (out_ready) begin
            out_valid <= 1'b0;
            last_id   <= cur_id;
            timer     <= '0;
            state     <= ACK;
          end
        end
        default: begin
          if (!fresh_bits[cur_id] || timer == TW'(ACK_TIMEOUT - 1)) begin
            rtl_rdy <= ~poll_mask & ~cur_hot;
            ack_err <= ack_err | fresh_bits[cur_id];
            state   <= IDLE;
          end else begin
            rtl_rdy <= ~poll_mask | cur_hot;
            timer   <= timer + TW'(1);
          end
        end
      endcase
    end
  end
`ifdef FRESH_POLL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) served_cnt <= '0;
    else if (state == PRESENT && out_ready) served_cnt <= served_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_fresh_poll_sched.sv
// tb_fresh_poll_sched: randomized scoreboard bench for fresh_poll_sched with an axi_slave fresh-bit model
module tb_fresh_poll_sched;
  localparam int N = 8, DW = 16, TO = 8, IW = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] fresh_bits = '0, poll_mask = '1, stuck = '0, rtl_rdy;
  logic [N-1:0][DW-1:0] rtl_rd_out = '0;
  logic out_valid, out_ready = 1'b0, ack_err, rand_ready = 1'b0;
  logic [IW-1:0] out_id;
  logic [DW-1:0] out_data;
`ifdef FRESH_POLL_STATS_EN
  logic [31:0] served_cnt;
`endif
  fresh_poll_sched #(.MEM_SIZE(N), .DATA_WIDTH(DW), .ACK_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .fresh_bits (fresh_bits),
    .rtl_rd_out (rtl_rd_out),
    .poll_mask  (poll_mask),
    .rtl_rdy    (rtl_rdy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_data   (out_data),
    .ack_err    (ack_err)
`ifdef FRESH_POLL_STATS_EN
    ,
    .served_cnt (served_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic [IW-1:0] id; logic [DW-1:0] data;} exp_t;
  exp_t sbq[$];
  int checks = 0, errors = 0, model_last = N - 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  // Reference model: pending masked IDs are served in rotation order after the last served ID.
  task automatic push_batch(input logic [N-1:0] pend);
    int start = model_last;
    for (int k = 1; k <= N; k++) begin
      int i = (start + k) % N;
      if (pend[i]) begin
        sbq.push_back('{id: IW'(i), data: rtl_rd_out[i]});
        model_last = i;
      end
    end
  endtask
  // Slave model: a fresh bit clears once the slave has seen rtl_rdy high for it, unless held stuck.
  task automatic step();
    @(negedge clk);
    fresh_bits = fresh_bits & ~(rtl_rdy & ~stuck);
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic do_reset();
    fresh_bits = '0;
    stuck = '0;
    rst = 1'b1;
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_rdy", rtl_rdy, 0);
    chk("rst_id", out_id, 0);
    chk("rst_data", out_data, 0);
    chk("rst_err", ack_err, 0);
    rst = 1'b0;
    model_last = N - 1;
  endtask
  task automatic drain();
    int c = 0;
    while (c < 400 && !(sbq.size() == 0 && (fresh_bits & poll_mask) == 0 && !out_valid
                        && (rtl_rdy & poll_mask) == 0)) begin
      step();
      c++;
    end
    checks++;
    if (c >= 400) begin
      errors++;
      $display("FAIL drain_timeout pending %0d want 0", sbq.size());
      sbq.delete();
    end
    step();
    step();
  endtask
  // Monitor: pops the scoreboard on every handshake and checks stream stability while stalled.
  initial begin
    logic pv, phs;
    logic [IW-1:0] pid;
    logic [DW-1:0] pdata;
    exp_t e;
    pv = 1'b0;
    phs = 1'b0;
    pid = '0;
    pdata = '0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) pv = 1'b0;
      else begin
        if (pv && !phs) begin
          chk("valid_held", out_valid, 1);
          chk("id_stable", out_id, pid);
          chk("data_stable", out_data, pdata);
        end
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out got id %0d want none", out_id);
          end else begin
            e = sbq.pop_front();
            chk("out_id", out_id, e.id);
            chk("out_data", out_data, e.data);
          end
        end
        pv = out_valid;
        pid = out_id;
        pdata = out_data;
        phs = out_valid && out_ready;
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int c, cnt;
    do_reset();
    out_ready = 1'b1;
    rtl_rd_out[2] = 16'd5;
    fresh_bits[2] = 1'b1;
    push_batch(8'b0000_0100);
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_id", out_id, 2);
    chk("t1_data", out_data, 5);
    step();
    chk("t1_rdy_up", rtl_rdy[2], 1);
    chk("t1_valid_low", out_valid, 0);
    step();
    chk("t1_rdy_down", rtl_rdy[2], 0);
    drain();
    do_reset();
    rtl_rd_out[1] = 16'h1111;
    rtl_rd_out[3] = 16'h3333;
    rtl_rd_out[6] = 16'h6666;
    fresh_bits = 8'b0100_1010;
    push_batch(8'b0100_1010);
    c = 0;
    while (c < 50 && !(out_valid && out_id == 3)) begin
      step();
      c++;
    end
    chk("t2_reach_id3", out_valid && out_id == 3, 1);
    rtl_rd_out[1] = 16'h1A1A;
    fresh_bits[1] = 1'b1;
    push_batch(8'b0000_0010);
    drain();
    do_reset();
    out_ready = 1'b0;
    rtl_rd_out[3] = 16'hBEEF;
    fresh_bits[3] = 1'b1;
    push_batch(8'b0000_1000);
    step();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) rtl_rd_out[3] = 16'h1234;
      step();
      chk("t3_valid", out_valid, 1);
      chk("t3_hold_data", out_data, 16'hBEEF);
      chk("t3_rdy_low", rtl_rdy[3], 0);
    end
    out_ready = 1'b1;
    drain();
    poll_mask = 8'b0000_0001;
    do_reset();
    step();
    chk("t4_unmasked_rdy", rtl_rdy, 8'hFE);
    fresh_bits[4] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t4_no_valid", out_valid, 0);
    end
    poll_mask = '1;
    do_reset();
    stuck[5] = 1'b1;
    rtl_rd_out[5] = 16'h5A5A;
    fresh_bits[5] = 1'b1;
    push_batch(8'b0010_0000);
    c = 0;
    cnt = 0;
    while (!rtl_rdy[5] && c < 40) begin
      step();
      c++;
    end
    while (rtl_rdy[5] && c < 80) begin
      cnt++;
      step();
      c++;
    end
    stuck = '0;
    fresh_bits[5] = 1'b0;
    chk("t5_rdy_cycles", cnt, TO);
    chk("t5_err_set", ack_err, 1);
    step();
    step();
    step();
    chk("t5_err_sticky", ack_err, 1);
    chk("t5_no_resched", out_valid, 0);
    do_reset();
`ifdef FRESH_POLL_STATS_EN
    for (int i = 0; i < N; i++) rtl_rd_out[i] = DW'($urandom);
    fresh_bits = 8'b1011_0101;
    push_batch(8'b1011_0101);
    drain();
    chk("t6_served5", served_cnt, 5);
    stuck[2] = 1'b1;
    fresh_bits[2] = 1'b1;
    push_batch(8'b0000_0100);
    c = 0;
    while (!rtl_rdy[2] && c < 40) begin
      step();
      c++;
    end
    step();
    chk("t6_mid_ack", rtl_rdy[2], 1);
    rst = 1'b1;
    step();
    chk("t6_cnt_clr", served_cnt, 0);
    chk("t6_rdy_clr", rtl_rdy, 0);
    chk("t6_valid_clr", out_valid, 0);
    do_reset();
`endif
    rand_ready = 1'b1;
    for (int r = 0; r < 40; r++) begin
      logic [N-1:0] pend;
      poll_mask = N'($urandom);
      pend = N'($urandom);
      for (int i = 0; i < N; i++) if (pend[i]) rtl_rd_out[i] = DW'($urandom);
      fresh_bits = fresh_bits | pend;
      push_batch(pend & poll_mask);
      drain();
    end
    rand_ready = 1'b0;
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
